// File: rtl/lsu_if.sv
// Request, response and data-RAM port bundle for the load/store unit.
// master = execute/writeback/RAM side, slave = LSU side.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;
  logic              mem_en_read;
  logic              mem_en_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_size, req_unsigned,
    input  req_tag, resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata,
    output resp_tag, resp_err,
    output mem_en_read, mem_en_write, mem_addr,
    output mem_din, mem_size, mem_unsigned
  );

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_size, req_unsigned,
    output req_tag, resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_tag, resp_err,
    input  mem_en_read, mem_en_write, mem_addr,
    input  mem_din, mem_size, mem_unsigned
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: word-only RAM access, lane extract/extend, sub-word RMW.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word instead of aligning.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [TAG_W-1:0]  tag_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       din_q;

  logic              accept;
  logic [1:0]        off_in;
  logic [1:0]        off_eff;
  logic              err_in;
  logic [4:0]        sh;
  logic [31:0]       lane;
  logic [31:0]       mask;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign accept = (state_q == S_IDLE) && bus.req_valid;
  assign off_in = bus.req_addr[1:0];

  // Classify an incoming request: error flag and effective lane offset
  always_comb begin
    err_in  = (bus.req_size == 2'b11);
    off_eff = off_in;
`ifdef LSU_MISALIGN_TRAP_EN
    if (bus.req_size == 2'b01 && off_in[0])
      err_in = 1'b1;
    if (bus.req_size == 2'b10 && off_in != 2'b00)
      err_in = 1'b1;
`else
    if (bus.req_size == 2'b01)
      off_eff = {off_in[1], 1'b0};
    else if (bus.req_size == 2'b10)
      off_eff = 2'b00;
`endif
  end

  // Lane extraction with extension, and lane merge for sub-word stores
  always_comb begin
    sh   = {off_q, 3'b000};
    lane = bus.mem_dout >> sh;
    unique case (size_q)
      2'b00:   mask = 32'h0000_00ff;
      2'b01:   mask = 32'h0000_ffff;
      default: mask = 32'hffff_ffff;
    endcase
    unique case (size_q)
      2'b00:
        load_val = uns_q ? {24'd0, lane[7:0]}
                         : {{24{lane[7]}}, lane[7:0]};
      2'b01:
        load_val = uns_q ? {16'd0, lane[15:0]}
                         : {{16{lane[15]}}, lane[15:0]};
      default:
        load_val = bus.mem_dout;
    endcase
    merged = (bus.mem_dout & ~(mask << sh))
           | ((wdata_q & mask) << sh);
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept) begin
          if (err_in)
            state_d = S_RESP;
          else if (bus.req_write && bus.req_size == 2'b10)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = write_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:
        if (bus.resp_ready)
          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        off_q   <= off_eff;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        tag_q   <= bus.req_tag;
        err_q   <= err_in;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        din_q   <= bus.req_wdata;
      end
      if (state_q == S_WAIT) begin
        if (write_q)
          din_q <= merged;
        else
          rdata_q <= load_val;
      end
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.resp_valid   = (state_q == S_RESP);
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_tag     = tag_q;
  assign bus.resp_err     = err_q;
  assign bus.mem_en_read  = (state_q == S_READ);
  assign bus.mem_en_write = (state_q == S_WRITE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_din      = din_q;
  assign bus.mem_size     = 2'b10;
  assign bus.mem_unsigned = 1'b1;

endmodule
